sgpu_fetch: RTL and testbench

Framebuffer fetch engine for the sgpu VGA path. It sits upstream of the pixel FIFO and reads one frame of 32-bit pixels from memory over an ICB master port. The frame starts at the active framebuffer base (`addr_offset`) and each pixel is pushed in raster order into the FIFO write side. It starts a frame when the display controller raises `openChal`, and stops when the frame completes or `openChal` drops early.

---
 rtl/sgpu_fetch_if.sv | 29 ++
 rtl/sgpu_fetch.sv | 198 +++++++++++++++++++
 tb/tb_sgpu_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgpu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : sgpu_fetch_if
// Purpose  : ICB read-channel bundle between the sgpu fetch engine and memory.
// Revision : 1.0  initial release
// ============================================================================
interface sgpu_fetch_if;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_vld, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_rdy,
        input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_vld, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_rdy,
        output cmd_rdy, rsp_vld, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/sgpu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sgpu_fetch
// Purpose  : Framebuffer fetch engine: reads one frame of pixels over ICB and
//            pushes them in raster order into the pixel FIFO.
//            Optional macro SGPU_FETCH_STAT_EN adds frame/abort counters.
// Revision : 1.0  initial release
// ============================================================================
module sgpu_fetch #(
    parameter int  SCR_W      = 800,
    parameter int  SCR_H      = 600,
    parameter int  MAX_OUTSTD = 4,
    parameter int  FIFO_DEPTH = 512,
    localparam int FREE_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  wire                clk,
    input  wire                rst,
    input  wire  [31:0]        addr_offset,
    input  wire                openChal,
    sgpu_fetch_if.master       icb,
    output logic               fifo_w_req,
    output logic [31:0]        fifo_w_data,
    input  wire  [FREE_W-1:0]  fifo_wfree,
    output logic               busy,
    output logic               fetch_err,
    output logic               abort_flag
`ifdef SGPU_FETCH_STAT_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        abort_cnt
`endif
);

    localparam int NPIX  = SCR_W * SCR_H;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int OW    = $clog2(MAX_OUTSTD + 1);
    localparam int CW    = FREE_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             oc_s1;
    logic             oc_s2;
    logic             oc_s3;
    logic             start;
    logic             stop;
    logic [31:0]      base;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] push_idx;
    logic [OW-1:0]    outstd;
    logic [OW-1:0]    outstd_nxt;
    logic             push_pend;
    logic             cmd_hold;
    logic             cmd_hs;
    logic             rsp_hs;
    logic             can_issue;
    logic             frame_done;
    logic [CW-1:0]    credit;

    // openChal lives in the vga_clk domain; two flops plus one for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oc_s1 <= 1'b0;
            oc_s2 <= 1'b0;
            oc_s3 <= 1'b0;
        end else begin
            oc_s1 <= openChal;
            oc_s2 <= oc_s1;
            oc_s3 <= oc_s2;
        end
    end

    assign start = oc_s2 & ~oc_s3;
    assign stop  = ~oc_s2 & oc_s3;

    // Every outstanding read and the pending push already own a FIFO slot
    assign credit    = CW'(outstd) + CW'(push_pend);
    assign can_issue = (issue_idx < IDX_W'(NPIX)) &&
                       (outstd < OW'(MAX_OUTSTD)) &&
                       (credit < CW'(fifo_wfree));

    assign icb.cmd_vld   = cmd_hold | ((state == RUN) & can_issue);
    assign icb.cmd_addr  = base + 32'({issue_idx, 2'b00});
    assign icb.cmd_read  = 1'b1;
    assign icb.cmd_wdata = 32'h0;
    assign icb.cmd_wmask = 4'hf;
    assign icb.rsp_rdy   = 1'b1;

    assign cmd_hs     = icb.cmd_vld & icb.cmd_rdy;
    assign rsp_hs     = icb.rsp_vld & (state != IDLE);
    assign frame_done = (push_idx == IDX_W'(NPIX)) && (outstd == '0);

    assign fifo_w_req = push_pend;
    assign busy       = (state != IDLE);

    always_comb begin
        outstd_nxt = outstd;
        if (cmd_hs && !rsp_hs) begin
            outstd_nxt = outstd + OW'(1);
        end else if (!cmd_hs && rsp_hs) begin
            outstd_nxt = outstd - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (frame_done) begin
                    state_nxt = IDLE;
                end else if (stop) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstd == '0) && !cmd_hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base        <= 32'h0;
            issue_idx   <= '0;
            push_idx    <= '0;
            outstd      <= '0;
            cmd_hold    <= 1'b0;
            push_pend   <= 1'b0;
            fifo_w_data <= 32'h0;
            fetch_err   <= 1'b0;
            abort_flag  <= 1'b0;
        end else begin
            cmd_hold  <= icb.cmd_vld & ~icb.cmd_rdy;
            outstd    <= outstd_nxt;
            push_pend <= icb.rsp_vld & (state == RUN);
            if (icb.rsp_vld && (state == RUN)) begin
                fifo_w_data <= icb.rsp_err ? 32'h0 : icb.rsp_rdata;
            end
            if (icb.rsp_vld && icb.rsp_err) begin
                fetch_err <= 1'b1;
            end
            if ((state == RUN) && (state_nxt == DRAIN)) begin
                abort_flag <= 1'b1;
            end
            if ((state == IDLE) && start) begin
                base      <= addr_offset;
                issue_idx <= '0;
                push_idx  <= '0;
            end else begin
                if (cmd_hs) begin
                    issue_idx <= issue_idx + IDX_W'(1);
                end
                if (push_pend) begin
                    push_idx <= push_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef SGPU_FETCH_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= 16'h0;
            abort_cnt <= 16'h0;
        end else begin
            if ((state == RUN) && (state_nxt == IDLE)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((state == RUN) && (state_nxt == DRAIN)) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sgpu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgpu_fetch
// Purpose  : Self-checking bench for sgpu_fetch with a zero-wait memory model
//            and a FIFO-word scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_sgpu_fetch;
    localparam int SCR_W      = 4;
    localparam int SCR_H      = 2;
    localparam int NPIX       = SCR_W * SCR_H;
    localparam int MAX_OUTSTD = 4;
    localparam int FIFO_DEPTH = 512;
    localparam int FREE_W     = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [31:0]       addr_offset;
    logic              openChal;
    logic              fifo_w_req;
    logic [31:0]       fifo_w_data;
    logic [FREE_W-1:0] fifo_wfree;
    logic              busy;
    logic              fetch_err;
    logic              abort_flag;
`ifdef SGPU_FETCH_STAT_EN
    logic [15:0]       frame_cnt;
    logic [15:0]       abort_cnt;
`endif

    sgpu_fetch_if m_icb ();

    sgpu_fetch #(
        .SCR_W      (SCR_W),
        .SCR_H      (SCR_H),
        .MAX_OUTSTD (MAX_OUTSTD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_offset (addr_offset),
        .openChal    (openChal),
        .icb         (m_icb),
        .fifo_w_req  (fifo_w_req),
        .fifo_w_data (fifo_w_data),
        .fifo_wfree  (fifo_wfree),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .abort_flag  (abort_flag)
`ifdef SGPU_FETCH_STAT_EN
        ,
        .frame_cnt   (frame_cnt),
        .abort_cnt   (abort_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    int acc = 0;
    int rsp_idx = 0;
    int rsp_done = 0;
    int wr_cnt = 0;
    int spurious = 0;
    int fill = 0;
    int cap = 512;
    int cmd_limit = 1000;
    int rsp_limit = 1000;
    int err_at = -1;
    int stall_left = 0;
    bit sb_en = 1'b1;
    bit stall_on = 1'b0;
    bit stall_seen = 1'b0;
    bit credit_on = 1'b0;
    logic [31:0] cur_base = 32'h0;
    logic [31:0] ra;
    logic [31:0] rd;
    logic [31:0] pend[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, ~a[15:0]};
    endfunction

    // Memory slave and FIFO model: drive at negedge, sample 1 time unit later
    initial begin
        m_icb.cmd_rdy   = 1'b0;
        m_icb.rsp_vld   = 1'b0;
        m_icb.rsp_rdata = 32'h0;
        m_icb.rsp_err   = 1'b0;
        fifo_wfree      = FREE_W'(cap);
        forever begin
            @(negedge clk);
            if (pend.size() > 0 && rsp_idx < rsp_limit) begin
                ra = pend.pop_front();
                rd = mem_word(ra);
                m_icb.rsp_vld   = 1'b1;
                m_icb.rsp_rdata = rd;
                m_icb.rsp_err   = (rsp_idx == err_at);
                if (sb_en) exp_q.push_back((rsp_idx == err_at) ? 32'h0 : rd);
                rsp_idx++;
            end else begin
                m_icb.rsp_vld = 1'b0;
                m_icb.rsp_err = 1'b0;
            end
            m_icb.cmd_rdy = (acc < cmd_limit) && !(stall_on && acc == 2 && stall_left > 0);
            fifo_wfree    = FREE_W'(cap - fill);
            #1;
            if (credit_on)
                chk("credit", 32'((acc - rsp_done + (fifo_w_req ? 1 : 0)) <= int'(fifo_wfree)), 32'd1);
            if (m_icb.rsp_vld) rsp_done++;
            if (stall_on && acc == 2 && stall_left > 0) begin
                if (m_icb.cmd_vld) stall_seen = 1'b1;
                if (stall_seen) begin
                    chk("stall_vld", 32'(m_icb.cmd_vld), 32'd1);
                    chk("stall_addr", m_icb.cmd_addr, cur_base + 32'd8);
                    stall_left--;
                end
            end
            if (m_icb.cmd_vld && m_icb.cmd_rdy) begin
                chk("cmd_addr", m_icb.cmd_addr, cur_base + 32'(acc * 4));
                pend.push_back(m_icb.cmd_addr);
                acc++;
            end
            if (fifo_w_req) begin
                wr_cnt++;
                fill++;
                if (exp_q.size() > 0) chk("fifo_data", fifo_w_data, exp_q.pop_front());
                else spurious++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic frame_start(input logic [31:0] b);
        cur_base    = b;
        addr_offset = b;
        acc         = 0;
        rsp_idx     = 0;
        rsp_done    = 0;
        wr_cnt      = 0;
        spurious    = 0;
        fill        = 0;
        exp_q.delete();
        openChal    = 1'b1;
    endtask

    task automatic wait_frame(input string tag);
        int t;
        t = 0;
        while (!busy && t < 20) begin
            tick(1);
            t++;
        end
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        t = 0;
        while (busy && t < 500) begin
            tick(1);
            t++;
        end
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        openChal = 1'b0;
        tick(4);
    endtask

    task automatic check_frame_ok(input string tag);
        chk({tag, "_writes"}, 32'(wr_cnt), NPIX);
        chk({tag, "_reads"}, 32'(acc), NPIX);
        chk({tag, "_spurious"}, 32'(spurious), 32'd0);
        chk({tag, "_expq"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int t;
        int wr0;
        int acc0;
        rst         = 1'b0;
        openChal    = 1'b0;
        addr_offset = 32'h0;
        tick(3);
        chk("rst_cmd_vld", 32'(m_icb.cmd_vld), 32'd0);
        chk("rst_cmd_addr", m_icb.cmd_addr, 32'h0);
        chk("rst_w_req", 32'(fifo_w_req), 32'd0);
        chk("rst_w_data", fifo_w_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_abort", 32'(abort_flag), 32'd0);
        chk("rst_rsp_rdy", 32'(m_icb.rsp_rdy), 32'd1);
        chk("cmd_read", 32'(m_icb.cmd_read), 32'd1);
        chk("cmd_wmask", 32'(m_icb.cmd_wmask), 32'hf);
        rst = 1'b1;
        tick(3);

        // 1: plain frame
        frame_start(32'hc000_0000);
        wait_frame("t1");
        check_frame_ok("t1");
        chk("t1_fetch_err", 32'(fetch_err), 32'd0);
        chk("t1_abort", 32'(abort_flag), 32'd0);
`ifdef SGPU_FETCH_STAT_EN
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
`endif

        // 2: FIFO nearly full
        cap = 2;
        credit_on = 1'b1;
        frame_start(32'h0000_1000);
        tick(40);
        chk("t2_writes_capped", 32'(wr_cnt), 32'd2);
        cap = 512;
        wait_frame("t2");
        credit_on = 1'b0;
        check_frame_ok("t2");

        // 3: command stall on the third read
        stall_on   = 1'b1;
        stall_left = 5;
        stall_seen = 1'b0;
        frame_start(32'h2000_0000);
        wait_frame("t3");
        stall_on = 1'b0;
        chk("t3_stall_done", 32'(stall_left), 32'd0);
        check_frame_ok("t3");

        // 4: bus error on the fifth response
        err_at = 4;
        frame_start(32'h3000_0000);
        wait_frame("t4");
        err_at = -1;
        check_frame_ok("t4");
        chk("t4_fetch_err", 32'(fetch_err), 32'd1);

        // 5: early drop of openChal
        cmd_limit = 5;
        rsp_limit = 3;
        frame_start(32'h4000_0000);
        t = 0;
        while (!(wr_cnt == 3 && acc == 5) && t < 100) begin
            tick(1);
            t++;
        end
        chk("t5_reach_wr", 32'(wr_cnt), 32'd3);
        chk("t5_reach_acc", 32'(acc), 32'd5);
        openChal = 1'b0;
        sb_en    = 1'b0;
        tick(6);
        chk("t5_drain_busy", 32'(busy), 32'd1);
        chk("t5_abort", 32'(abort_flag), 32'd1);
        cmd_limit = 1000;
        rsp_limit = 1000;
        t = 0;
        while (busy && t < 100) begin
            tick(1);
            t++;
        end
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_no_more_wr", 32'(wr_cnt), 32'd3);
        chk("t5_held_cmd_taken", 32'(acc), 32'd6);
        chk("t5_pend_empty", 32'(pend.size()), 32'd0);
        chk("t5_spurious", 32'(spurious), 32'd0);
        chk("t5_fetch_err_sticky", 32'(fetch_err), 32'd1);
`ifdef SGPU_FETCH_STAT_EN
        chk("t5_abort_cnt", 32'(abort_cnt), 32'd1);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd4);
`endif
        sb_en = 1'b1;
        tick(3);
        frame_start(32'h5000_0000);
        wait_frame("t5b");
        check_frame_ok("t5b");
`ifdef SGPU_FETCH_STAT_EN
        chk("t5b_frame_cnt", 32'(frame_cnt), 32'd5);
`endif

        // 6: reset in the middle of a frame
        frame_start(32'h6000_0000);
        t = 0;
        while (wr_cnt < 3 && t < 100) begin
            tick(1);
            t++;
        end
        chk("t6_reach_wr", 32'(wr_cnt >= 3), 32'd1);
        rst      = 1'b0;
        openChal = 1'b0;
        sb_en    = 1'b0;
        #1;
        chk("t6_cmd_vld", 32'(m_icb.cmd_vld), 32'd0);
        chk("t6_cmd_addr", m_icb.cmd_addr, 32'h0);
        chk("t6_w_req", 32'(fifo_w_req), 32'd0);
        chk("t6_w_data", fifo_w_data, 32'h0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_fetch_err", 32'(fetch_err), 32'd0);
        chk("t6_abort", 32'(abort_flag), 32'd0);
        chk("t6_rsp_rdy", 32'(m_icb.rsp_rdy), 32'd1);
`ifdef SGPU_FETCH_STAT_EN
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        wr0  = wr_cnt;
        acc0 = acc;
        tick(2);
        rst = 1'b1;
        tick(10);
        chk("t6_no_late_wr", 32'(wr_cnt), 32'(wr0));
        chk("t6_no_new_cmd", 32'(acc), 32'(acc0));
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_pend_drained", 32'(pend.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
